eth_mii_rx: RTL and testbench
=============================

// Module: eth_mii_rx
// PURPOSE
//  MII receive path: samples PHY nibbles on eth_rx_clk, strips preamble/SFD, assembles bytes,
//  streams them to downstream logic, checks FCS/length/PHY errors, and reports per-frame status.
//  It is the receive counterpart of the MII transmit block and sits between PHY pins and the host capture FIFO.
// PARAMETERS
//  MAC_ADDR   48'h000203040506  station address for dest-address match
//  PROMISC    0                 1: rx_addr_match always 1
//  MIN_PRE    2                 min 0x5 preamble nibbles required before SFD nibble 0xD
//  MIN_LEN    64                min bytes after SFD (incl. FCS); fewer -> runt
//  MAX_LEN    1518              max bytes after SFD (incl. FCS); more -> oversize
// PORTS
//  eth_rx_clk     in   1   PHY receive clock; all logic on posedge
//  reset_i        in   1   asynchronous, active-high reset
//  eth_rx_data    in   4   MII receive nibble, low nibble of each byte first
//  eth_rx_dv      in   1   MII receive data valid
//  eth_rx_er      in   1   MII receive error
//  rx_data        out  8   received byte (dest MAC .. FCS)
//  rx_valid       out  1   1-cycle strobe, rx_data valid
//  rx_sof         out  1   high with rx_valid on first byte after SFD
//  rx_done        out  1   1-cycle strobe at frame end; status outputs valid with it and held until next rx_done
//  rx_good        out  1   rx_status == 0
//  rx_status      out  5   {crc_err, align_err, phy_err, runt, oversize}
//  rx_len         out  16  bytes received after SFD incl. FCS (saturates at MAX_LEN+1)
//  rx_addr_match  out  1   dest == MAC_ADDR, or dest == broadcast, or PROMISC
// BEHAVIOUR
//  Reset: all outputs 0; state = WAIT_IDLE; CRC = 32'hFFFFFFFF; byte counter 0; nibble phase 0.
//  FSM:
//   WAIT_IDLE: eth_rx_dv low for 1 cycle -> IDLE. Guards release of reset in the middle of a frame.
//   IDLE: dv=1 & nibble 0x5 -> PREAMBLE (pre_cnt=1); dv=1 & other nibble -> DROP.
//   PREAMBLE: 0x5 -> pre_cnt++.
//     0xD & pre_cnt>=MIN_PRE -> DATA (phase=0, CRC init, len=0).
//     Any other nibble, 0xD too early, or dv=0 -> DROP/IDLE; no rx_done.
//   DATA: phase 0 latches low nibble; phase 1 forms {hi,lo}.
//     rx_valid/rx_data are registered and appear 1 clk after the high-nibble edge.
//     Bytes pass into CRC and len++. First 6 bytes build the dest shift register.
//     rx_sof accompanies byte 0.
//     dv=0 -> rx_done next cycle -> IDLE.
//     len reaches MAX_LEN+1 -> set oversize, stop rx_valid, -> DROP (rx_done fires when dv falls).
//   DROP: ignore nibbles until dv=0 -> IDLE (rx_done only if entered from DATA).
//  Status evaluated at dv fall in DATA:
//   align_err: phase==1 (odd nibble count); the dangling nibble is discarded.
//   phy_err: eth_rx_er sampled high at any cycle with dv=1 while in DATA.
//   runt: len < MIN_LEN.
//   crc_err: CRC register != 32'hDEBB20E3 (residue).
//  CRC-32 is reflected and LSB-first: poly 32'hEDB88320, init 32'hFFFFFFFF, one byte per rx_valid.
//  rx_addr_match is computed after byte 5. If fewer than 6 bytes are received, it is 0.
//  dv dropping mid-preamble or eth_rx_er in IDLE/PREAMBLE: frame silently discarded, no rx_done.
//  Back-to-back frames: dv low for 1 cycle is sufficient; rx_done and the new IDLE detection may coincide.
//  Async reset mid-frame: outputs clear immediately; no rx_done for the aborted frame.
// STRUCTURE
//  Shared header eth_pkg.vh:
//   FSM state encodings.
//   Preamble/SFD nibble constants.
//   CRC poly/init/residue constants.
//   Default MIN_LEN/MAX_LEN.
//  Sub-module eth_crc32_d8: byte-wide reflected CRC-32.
//   Ports: clk, reset_i, init, en, d[7:0], crc[31:0].
//   Registered with async reset. Shared with later TX rework.
//  The top holds the FSM, nibble assembler, counters, address compare, and status regs.
// TESTING
//  1. 7x0x55+0xD5, 60B payload to MAC_ADDR, valid FCS
//     -> 64 rx_valid, rx_sof on byte 0, rx_len=64, rx_good=1, rx_addr_match=1.
//  2. Same frame with one payload bit flipped
//     -> rx_status=5'b10000, rx_good=0, rx_len=64.
//  3. dv drops after odd nibble count (129 nibbles)
//     -> align_err=1; 64 bytes streamed.
//     Separately: rx_er pulse mid-DATA -> phy_err=1.
//  4. 40-byte frame with valid FCS -> runt=1.
//     1600-byte frame -> rx_valid stops after 1518 bytes; oversize=1, rx_len=1519.
//  5. Dest FF:FF:FF:FF:FF:FF -> addr_match=1.
//     Dest 00:11:22:33:44:55 -> 0 (PROMISC=0), 1 (PROMISC=1).
//  6. Assert reset_i mid-DATA, release with dv still high
//     -> no rx_valid/rx_done until dv low.
//     Next clean frame -> rx_good=1.
//     Then two frames separated by 1 idle cycle -> two rx_done, both good.

Source files
------------

// File: rtl/eth_mii_rx_pkg.sv
// Shared definitions for the MII receive path: FSM state encoding,
// preamble/SFD nibble values, CRC-32 constants, default frame length limits
// and a byte-wide reflected CRC-32 step function.
package eth_mii_rx_pkg;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } rx_state_t;

  localparam logic [3:0]  NIB_PRE     = 4'h5;
  localparam logic [3:0]  NIB_SFD     = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;

  // One byte of reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 register (poly EDB88320, init FFFFFFFF).
// Ports:
//   clk, reset_i : clock, async active-high reset (register -> init value)
//   init         : load init value (wins over en)
//   en           : fold d into the CRC
//   d            : data byte
//   crc          : current (non-inverted) CRC register
module eth_crc32_d8
  import eth_mii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, d);
  end

  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;

  assign crc = crc_q;

endmodule

// File: rtl/eth_mii_rx.sv
// MII receive path. Strips preamble/SFD, assembles nibbles into bytes,
// streams bytes (dest MAC .. FCS), and reports per-frame status at frame end.
// Ports:
//   eth_rx_clk, reset_i          : PHY rx clock, async active-high reset
//   eth_rx_data/dv/er            : MII receive nibble, data valid, error
//   rx_data/rx_valid/rx_sof      : byte stream, 1-cycle strobe, first-byte flag
//   rx_done                      : 1-cycle end-of-frame strobe
//   rx_good/rx_status/rx_len/
//   rx_addr_match                : frame status, held until the next rx_done
module eth_mii_rx
  import eth_mii_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h000203040506,
  parameter bit          PROMISC  = 1'b0,
  parameter int          MIN_PRE  = 2,
  parameter int          MIN_LEN  = DEF_MIN_LEN,
  parameter int          MAX_LEN  = DEF_MAX_LEN
) (
  input  logic        eth_rx_clk,
  input  logic        reset_i,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic        rx_good,
  output logic [4:0]  rx_status,
  output logic [15:0] rx_len,
  output logic        rx_addr_match
);

  localparam logic [3:0]  PRE_MIN = 4'(MIN_PRE);
  localparam logic [15:0] LEN_MIN = 16'(MIN_LEN);
  localparam logic [15:0] LEN_OVF = 16'(MAX_LEN + 1);

  rx_state_t   state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [15:0] len_q, len_d;
  logic [47:0] dest_q, dest_d;
  logic        phy_err_q, phy_err_d;
  logic        owe_done_q, owe_done_d;   // DROP entered from DATA (oversize)
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, done_q, done_d, good_q, good_d;
  logic [4:0]  status_q, status_d;
  logic [15:0] olen_q, olen_d;
  logic        match_q, match_d;

  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic [7:0]  byte_w;
  logic [15:0] len_inc;
  logic        match_w;

  assign byte_w  = {eth_rx_data, lo_q};
  assign len_inc = len_q + 16'd1;
  assign match_w = (len_q >= 16'd6) &&
                   (PROMISC || dest_q == MAC_ADDR || dest_q == 48'hFFFF_FFFF_FFFF);

  eth_crc32_d8 u_crc (
    .clk     (eth_rx_clk),
    .reset_i (reset_i),
    .init    (crc_init),
    .en      (crc_en),
    .d       (byte_w),
    .crc     (crc)
  );

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    lo_d       = lo_q;
    len_d      = len_q;
    dest_d     = dest_q;
    phy_err_d  = phy_err_q;
    owe_done_d = owe_done_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    done_d     = 1'b0;
    good_d     = good_q;
    status_d   = status_q;
    olen_d     = olen_q;
    match_d    = match_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      // Hold off until the line is quiet so a reset released mid-frame
      // cannot lock onto the tail of that frame.
      S_WAIT_IDLE: if (!eth_rx_dv) state_d = S_IDLE;

      S_IDLE: if (eth_rx_dv) begin
        if (eth_rx_data == NIB_PRE && !eth_rx_er) begin
          state_d   = S_PRE;
          pre_cnt_d = 4'd1;
        end else begin
          state_d    = S_DROP;
          owe_done_d = 1'b0;
        end
      end

      S_PRE: begin
        if (!eth_rx_dv) state_d = S_IDLE;
        else if (eth_rx_er) begin
          state_d    = S_DROP;
          owe_done_d = 1'b0;
        end else if (eth_rx_data == NIB_PRE) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (eth_rx_data == NIB_SFD && pre_cnt_q >= PRE_MIN) begin
          state_d   = S_DATA;
          phase_d   = 1'b0;
          len_d     = 16'd0;
          phy_err_d = 1'b0;
          crc_init  = 1'b1;
        end else begin
          state_d    = S_DROP;
          owe_done_d = 1'b0;
        end
      end

      S_DATA: begin
        if (!eth_rx_dv) begin
          // A dangling low nibble (phase_q==1) is simply never used.
          state_d  = S_IDLE;
          done_d   = 1'b1;
          status_d = {crc != CRC_RESIDUE, phase_q, phy_err_q, len_q < LEN_MIN, 1'b0};
          good_d   = (crc == CRC_RESIDUE) && !phase_q && !phy_err_q && !(len_q < LEN_MIN);
          olen_d   = len_q;
          match_d  = match_w;
        end else begin
          if (eth_rx_er) phy_err_d = 1'b1;
          if (!phase_q) begin
            lo_d    = eth_rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            len_d   = len_inc;
            crc_en  = 1'b1;
            if (len_q < 16'd6) dest_d = {dest_q[39:0], byte_w};
            if (len_inc == LEN_OVF) begin
              state_d    = S_DROP;
              owe_done_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              sof_d   = (len_q == 16'd0);
              data_d  = byte_w;
            end
          end
        end
      end

      S_DROP: if (!eth_rx_dv) begin
        state_d    = S_IDLE;
        owe_done_d = 1'b0;
        if (owe_done_q) begin
          // Truncated frame: CRC and alignment are meaningless, report
          // oversize plus any PHY error seen while still in DATA.
          done_d   = 1'b1;
          status_d = {2'b00, phy_err_q, 2'b01};
          good_d   = 1'b0;
          olen_d   = len_q;
          match_d  = match_w;
        end
      end

      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge eth_rx_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_WAIT_IDLE;
      pre_cnt_q  <= '0;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      phy_err_q  <= 1'b0;
      owe_done_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      status_q   <= '0;
      olen_q     <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      len_q      <= len_d;
      dest_q     <= dest_d;
      phy_err_q  <= phy_err_d;
      owe_done_q <= owe_done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      done_q     <= done_d;
      good_q     <= good_d;
      status_q   <= status_d;
      olen_q     <= olen_d;
      match_q    <= match_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_sof        = sof_q;
  assign rx_done       = done_q;
  assign rx_good       = good_q;
  assign rx_status     = status_q;
  assign rx_len        = olen_q;
  assign rx_addr_match = match_q;

endmodule

// File: tb/tb_eth_mii_rx.sv
`timescale 1ns/1ps
module tb_eth_mii_rx;

  localparam logic [47:0] MAC     = 48'h000203040506;
  localparam int          MIN_PRE = 2;
  localparam int          MIN_LEN = 64;
  localparam int          MAX_LEN = 1518;

  typedef struct {
    logic [4:0]  st;
    logic [4:0]  mask;
    logic [15:0] len;
    logic        m;
    logic        mp;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rxd;
  logic        dv, er;
  logic [7:0]  rx_data, p_data;
  logic        rx_valid, rx_sof, rx_done, rx_good, rx_addr_match;
  logic        p_valid, p_sof, p_done, p_good, p_match;
  logic [4:0]  rx_status, p_status;
  logic [15:0] rx_len, p_len;

  int total = 0, bad = 0, vcnt = 0, ndone = 0;
  logic [7:0] frm[$];
  logic [8:0] bq[$];     // {sof, data}
  done_t      dq[$];
  logic [8:0] e;
  done_t      d;

  always #5 clk = ~clk;

  eth_mii_rx #(.MAC_ADDR(MAC), .PROMISC(1'b0)) dut (
    .eth_rx_clk(clk), .reset_i(rst), .eth_rx_data(rxd), .eth_rx_dv(dv), .eth_rx_er(er),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_done(rx_done),
    .rx_good(rx_good), .rx_status(rx_status), .rx_len(rx_len), .rx_addr_match(rx_addr_match));

  eth_mii_rx #(.MAC_ADDR(MAC), .PROMISC(1'b1)) dut_p (
    .eth_rx_clk(clk), .reset_i(rst), .eth_rx_data(rxd), .eth_rx_dv(dv), .eth_rx_er(er),
    .rx_data(p_data), .rx_valid(p_valid), .rx_sof(p_sof), .rx_done(p_done),
    .rx_good(p_good), .rx_status(p_status), .rx_len(p_len), .rx_addr_match(p_match));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    return c;
  endfunction

  // Frame = dest(6) + pattern bytes up to 'body' bytes + FCS(4, LSB first).
  task automatic mk_frame(input logic [47:0] dest, input int body);
    logic [31:0] c;
    frm.delete();
    for (int k = 0; k < 6; k++) frm.push_back(dest[47-8*k -: 8]);
    for (int k = 6; k < body; k++) frm.push_back(8'(k*37 + 11));
    c = 32'hFFFFFFFF;
    for (int k = 0; k < body; k++) c = m_crc(c, frm[k]);
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  // Frame-level model: what must be streamed and reported for frm.
  task automatic expect_frame(input int pre_n, input int extra, input bit er_in, input int rst_nib);
    int n, ns;
    logic [31:0] c;
    logic [47:0] dst;
    done_t r;
    n = frm.size();
    if (pre_n < MIN_PRE) return;
    if (rst_nib >= 0) begin
      // byte whose high nibble lands on the edge before reset is wiped
      for (int k = 0; k < rst_nib/2 - 1; k++) bq.push_back({k == 0, frm[k]});
      return;
    end
    ns = (n > MAX_LEN) ? MAX_LEN : n;
    for (int k = 0; k < ns; k++) bq.push_back({k == 0, frm[k]});
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) c = m_crc(c, frm[k]);
    dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    r.len = 16'((n > MAX_LEN) ? MAX_LEN + 1 : n);
    if (n > MAX_LEN) begin
      r.st   = {2'b00, er_in, 2'b01};
      r.mask = 5'b00111;
    end else begin
      r.st   = {c != 32'hDEBB20E3, extra[0], er_in, n < MIN_LEN, 1'b0};
      r.mask = 5'b11111;
    end
    r.m  = (n >= 6) && (dst == MAC || dst == 48'hFFFF_FFFF_FFFF);
    r.mp = (n >= 6);
    dq.push_back(r);
  endtask

  task automatic drive(input logic [3:0] v, input logic dv_v, input logic er_v);
    @(posedge clk); #1;
    rxd = v; dv = dv_v; er = er_v;
  endtask

  task automatic send(input int pre_n, input int extra, input int er_nib, input int rst_nib, input int idle);
    int nn;
    for (int i = 0; i < pre_n; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    nn = 2*frm.size() + extra;
    for (int i = 0; i < nn; i++) begin
      @(posedge clk); #1;
      if (i == rst_nib) begin
        rst = 1'b1; #1;
        chk("rstmid_valid", 32'(rx_valid), 0);
        chk("rstmid_len",   32'(rx_len), 0);
        chk("rstmid_good",  32'(rx_good), 0);
      end
      if (i == rst_nib + 2) rst = 1'b0;
      rxd = (i >= 2*frm.size()) ? 4'hA : ((i % 2 == 0) ? frm[i/2][3:0] : frm[i/2][7:4]);
      dv  = 1'b1;
      er  = (i == er_nib);
    end
    for (int i = 0; i < idle; i++) drive(4'h0, 1'b0, 1'b0);
  endtask

  task automatic run(input int pre_n, input int extra, input int er_nib, input int rst_nib, input int idle);
    vcnt = 0;
    expect_frame(pre_n, extra, er_nib >= 0, rst_nib);
    send(pre_n, extra, er_nib, rst_nib, idle);
  endtask

  // Per-cycle compare against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        vcnt++;
        if (bq.size() == 0) chk("unexp_valid", 32'(rx_valid), 0);
        else begin
          e = bq.pop_front();
          chk("byte", 32'(rx_data), 32'(e[7:0]));
          chk("sof",  32'(rx_sof),  32'(e[8]));
        end
      end else if (rx_sof) chk("sof_no_valid", 32'(rx_sof), 0);
      if (rx_done || p_done) begin
        ndone++;
        if (dq.size() == 0) chk("unexp_done", 32'(rx_done), 0);
        else begin
          d = dq.pop_front();
          chk("done",    32'(rx_done), 1);
          chk("done_p",  32'(p_done), 1);
          chk("status",  32'(rx_status & d.mask), 32'(d.st & d.mask));
          chk("len",     32'(rx_len), 32'(d.len));
          chk("good",    32'(rx_good), 32'(d.st == 5'd0));
          chk("match",   32'(rx_addr_match), 32'(d.m));
          chk("match_p", 32'(p_match), 32'(d.mp));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c;
    int nd;
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_done",  32'(rx_done), 0);
    chk("rst_status",32'(rx_status), 0);
    chk("rst_len",   32'(rx_len), 0);
    chk("rst_good",  32'(rx_good), 0);
    chk("rst_match", 32'(rx_addr_match), 0);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 9; k++) c = m_crc(c, 8'h31 + 8'(k));
    chk("pin_crc_check", ~c, 32'hCBF43926);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: good 64-byte frame to our address
    mk_frame(MAC, 60);
    c = 32'hFFFFFFFF;
    foreach (frm[k]) c = m_crc(c, frm[k]);
    chk("pin_residue", c, 32'hDEBB20E3);
    run(15, 0, -1, -1, 4);
    chk("t1_nvalid", vcnt, 64);
    chk("t1_len",   32'(rx_len), 64);
    chk("t1_good",  32'(rx_good), 1);
    chk("t1_match", 32'(rx_addr_match), 1);

    // 2: payload bit flip
    mk_frame(MAC, 60);
    frm[20] = frm[20] ^ 8'h10;
    run(15, 0, -1, -1, 4);
    chk("t2_status", 32'(rx_status), 32'h10);
    chk("t2_len",    32'(rx_len), 64);

    // 3: odd nibble count, then PHY error mid-DATA
    mk_frame(MAC, 60);
    run(15, 1, -1, -1, 4);
    chk("t3_align",  32'(rx_status), 32'h08);
    chk("t3_nvalid", vcnt, 64);
    mk_frame(MAC, 60);
    run(15, 0, 50, -1, 4);
    chk("t3_phy", 32'(rx_status), 32'h04);

    // 4: runt and oversize
    mk_frame(MAC, 36);
    run(15, 0, -1, -1, 4);
    chk("t4_runt", 32'(rx_status), 32'h02);
    chk("t4_runt_len", 32'(rx_len), 40);
    mk_frame(MAC, 1596);
    run(15, 0, -1, -1, 4);
    chk("t4_ovf_nvalid", vcnt, 1518);
    chk("t4_ovf_len",    32'(rx_len), 1519);
    chk("t4_ovf_bit",    32'(rx_status[0]), 1);

    // 5: broadcast, foreign address
    mk_frame(48'hFFFF_FFFF_FFFF, 60);
    run(15, 0, -1, -1, 4);
    chk("t5_bcast", 32'(rx_addr_match), 1);
    mk_frame(48'h001122334455, 60);
    run(15, 0, -1, -1, 4);
    chk("t5_other",   32'(rx_addr_match), 0);
    chk("t5_other_p", 32'(p_match), 1);

    // short preamble: dropped silently
    nd = ndone;
    mk_frame(MAC, 60);
    run(1, 0, -1, -1, 4);
    chk("short_pre_nvalid", vcnt, 0);
    chk("short_pre_ndone",  ndone, nd);

    // 6: reset mid-DATA with dv held high
    nd = ndone;
    mk_frame(MAC, 60);
    run(15, 0, -1, 40, 4);
    chk("t6_rst_nvalid", vcnt, 19);
    chk("t6_rst_ndone",  ndone, nd);
    mk_frame(MAC, 60);
    run(15, 0, -1, -1, 4);
    chk("t6_clean_good", 32'(rx_good), 1);
    nd = ndone;
    mk_frame(MAC, 60);
    run(15, 0, -1, -1, 1);
    mk_frame(48'hFFFF_FFFF_FFFF, 62);
    run(15, 0, -1, -1, 4);
    chk("t6_b2b_ndone", ndone, nd + 2);
    chk("t6_b2b_good",  32'(rx_good), 1);

    repeat (10) @(posedge clk);
    chk("bq_empty", bq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
